redstone_comparator: RTL
========================

# redstone_comparator

Tick-accurate model of a redstone comparator, one stage downstream of the torch and repeater primitives. It takes a back strength and two side strengths and computes a compare-mode or subtract-mode output. Output changes go through a scheduled-update mechanism, so they appear a fixed number of game ticks after the update is scheduled. The block feeds dust, repeater or torch stages and uses the shared 4-bit `redstone` strength type.

## Interface
Parameters:
- `DELAY`, default 2: game ticks from scheduling an update to the output change. Legal range 1..15; elaboration error outside it.

Ports:
- `clk`, input, 1: one clock. Each `clk` edge with `tick_en` high is one game tick.
- `rst`, input, 1: reset, synchronous, active-high.
- `tick_en`, input, 1: game-tick qualifier. When low, all state holds.
- `back`, input, 4 (`redstone`): rear input strength, 0..15.
- `lside`, input, 4 (`redstone`): left side strength.
- `rside`, input, 4 (`redstone`): right side strength.
- `mode`, input, 1: 0 = compare, 1 = subtract.
- `out`, output, 4 (`redstone`): registered output strength.
- `out_on`, output, 1: registered; equals `out != 0`.
- `pending`, output, 1: high while an update is scheduled.

## Operation
- `side = max(lside, rside)`, combinational.
- `target`, combinational:
  - Compare mode: `back` if `back >= side`, else 0.
  - Subtract mode: `back - side`, saturating at 0. No wrap; computed at 5 bits internally and clamped.
- State machine `{IDLE, PENDING}` with a 4-bit countdown `cnt`. All transitions require `tick_en = 1`.
- IDLE:
  - If `target != out`: go to PENDING and load `cnt = DELAY-1`.
  - Otherwise stay in IDLE.
- PENDING:
  - If `cnt == 0`: set `out <= target`, using the target at that tick, not the target at scheduling time. Then go to IDLE.
  - Otherwise decrement `cnt`.
- Input changes while PENDING neither restart nor extend the countdown.
- If `target` equals `out` at expiry, `out` is unchanged. This is how glitches shorter than `DELAY` get swallowed.
- On the tick of return to IDLE, no new schedule is made. Re-evaluation happens on the next tick.
- Reset values: `out = 0`, `out_on = 0`, `pending = 0`, state IDLE, `cnt = 0`.
- Reset mid-PENDING discards the scheduled update.
- `rst` has priority over `tick_en`.

## Timing
- The schedule decision is made at tick T. `out` changes on the edge of tick T+DELAY.
- Minimum input-to-output latency is DELAY ticks.
- A new schedule can begin no earlier than tick T+DELAY+1, so the minimum output period is DELAY+1 ticks.
- `pending` is high from after edge T through edge T+DELAY.
- `out_on` updates on the same edge as `out`.
- With `tick_en` low, no state changes regardless of inputs.

## Configuration
- `REDSTONE_COMPARATOR_SUBTRACT_EN`:
  - Defined: the `mode` input selects compare or subtract as above.
  - Undefined: the `mode` port is still present but ignored, the block is always in compare mode, and no subtractor logic is generated.

## Structure
- Shared package `redstone_pkg`:
  - `typedef logic [3:0] redstone`
  - `REDSTONE_OFF = 0`, `REDSTONE_MAX = 15`
  - `typedef enum {CMP_COMPARE, CMP_SUBTRACT} cmp_mode_e`
  - State enum `comparator_state_e`
- One sub-module, `redstone_max2`: a combinational max of two strengths, used for the side inputs and reusable by the dust stage.

## Test plan
- Compare mode, DELAY=2, `back=10`, `side=0` applied at tick 0: `out=0` at ticks 0–1, `out=10` from tick 2; `pending` high ticks 0–2.
- Compare ties and losses: `back=5`, `lside=5` gives `out=5`. Then `rside=6` gives `out=0` two ticks later.
- Subtract mode (macro defined): `back=10`, `side=3` gives `out=7`. `back=3`, `side=10` gives `out=0` (saturation, no wrap to 9). With the macro undefined, `mode=1` and `back=10`, `side=3` gives `out=10`.
- Glitch swallow, DELAY=2: `back=15` for exactly 1 tick from an all-zero state. `out` stays 0, and `pending` pulses for 3 ticks.
- `tick_en` low for 5 cycles during PENDING: `cnt` and `out` frozen. The update lands DELAY qualified ticks after scheduling.
- `rst` asserted at tick 1 of a DELAY=3 pending update: next cycle `out=0`, `pending=0`, state IDLE. No late update appears.

Source files
------------

// File: rtl/redstone_pkg.sv
// Shared redstone types for the torch / repeater / comparator / dust stages.
// Holds the 4-bit strength type, its limits, the comparator mode and the
// comparator state encoding.
package redstone_pkg;

    typedef logic [3:0] redstone;

    localparam redstone REDSTONE_OFF = 4'd0;
    localparam redstone REDSTONE_MAX = 4'd15;

    typedef enum logic {
        CMP_COMPARE  = 1'b0,
        CMP_SUBTRACT = 1'b1
    } cmp_mode_e;

    typedef enum logic {
        CMP_IDLE    = 1'b0,
        CMP_PENDING = 1'b1
    } comparator_state_e;

    // Larger of two strengths; shared by side-input and dust merging.
    function automatic redstone redstone_max(input redstone a, input redstone b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/redstone_max2.sv
// Combinational max of two redstone strengths.
module redstone_max2
    import redstone_pkg::*;
(
    input  redstone i_a,
    input  redstone i_b,
    output redstone o_max
);

    assign o_max = redstone_max(i_a, i_b);

endmodule

// File: rtl/redstone_comparator.sv
// Tick-accurate redstone comparator.
// Output changes are scheduled and land DELAY game ticks later; the value
// written is the target at expiry, so pulses shorter than DELAY are swallowed.
// Optional feature: define REDSTONE_COMPARATOR_SUBTRACT_EN to enable subtract
// mode via the mode input; otherwise mode is ignored and only compare exists.
module redstone_comparator
    import redstone_pkg::*;
#(
    parameter int unsigned DELAY = 2
)
(
    input  logic    clk,
    input  logic    rst,
    input  logic    tick_en,
    input  redstone back,
    input  redstone lside,
    input  redstone rside,
    input  logic    mode,
    output redstone out,
    output logic    out_on,
    output logic    pending
);

    if (DELAY < 1 || DELAY > int'(REDSTONE_MAX)) begin : g_delay_check
        $error("redstone_comparator: DELAY must be in 1..15");
    end

    localparam logic [3:0] CNT_LOAD = 4'(DELAY - 1);

    comparator_state_e r_state;
    comparator_state_e w_state_nxt;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nxt;
    redstone           r_out;
    redstone           w_out_nxt;
    logic              r_out_on;
    redstone           w_side;
    redstone           w_target;

    redstone_max2 u_side_max (
        .i_a   (lside),
        .i_b   (rside),
        .o_max (w_side)
    );

`ifdef REDSTONE_COMPARATOR_SUBTRACT_EN
    cmp_mode_e  w_mode;
    logic [4:0] w_diff;

    assign w_mode = cmp_mode_e'(mode);
    // Borrow out of the 5-bit difference means side exceeded back.
    assign w_diff = {1'b0, back} - {1'b0, w_side};

    // Target strength: compare passes back through, subtract clamps at 0
    always_comb begin
        w_target = REDSTONE_OFF;
        if (w_mode == CMP_SUBTRACT) begin
            w_target = w_diff[4] ? REDSTONE_OFF : w_diff[3:0];
        end else begin
            w_target = (back >= w_side) ? back : REDSTONE_OFF;
        end
    end
`else
    logic w_unused_mode;
    assign w_unused_mode = mode;

    // Target strength: compare mode only, back passes if it holds off the sides
    always_comb begin
        w_target = REDSTONE_OFF;
        if (back >= w_side) begin
            w_target = back;
        end
    end
`endif

    // Scheduler next-state: arm on mismatch, count down, sample target at expiry
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_out_nxt   = r_out;
        if (tick_en) begin
            case (r_state)
                CMP_IDLE: begin
                    if (w_target != r_out) begin
                        w_state_nxt = CMP_PENDING;
                        w_cnt_nxt   = CNT_LOAD;
                    end
                end
                CMP_PENDING: begin
                    if (r_cnt == 4'd0) begin
                        w_out_nxt   = w_target;
                        w_state_nxt = CMP_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end
                end
                default: begin
                    w_state_nxt = CMP_IDLE;
                end
            endcase
        end
    end

    // State, countdown and output registers; reset wins over tick_en
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= CMP_IDLE;
            r_cnt    <= 4'd0;
            r_out    <= REDSTONE_OFF;
            r_out_on <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_out    <= w_out_nxt;
            r_out_on <= (w_out_nxt != REDSTONE_OFF);
        end
    end

    assign out     = r_out;
    assign out_on  = r_out_on;
    assign pending = (r_state == CMP_PENDING);

endmodule
